// File: rtl/demux_pkg.sv
// Shared constants, select type and select decode for the 1-to-4 demux.
package demux_pkg;

    localparam int NUM_LANES = 4;
    localparam int SEL_W     = 2;

    typedef logic [SEL_W-1:0] sel_t;

    function automatic logic [NUM_LANES-1:0] onehot4(input sel_t sel);
        return 4'b0001 << sel;
    endfunction

endpackage

// File: rtl/demux_1to4_comb.sv
// Combinational steering of p onto one of four lanes; ARCH 0 is an AND decode,
// any other ARCH value uses a behavioural case. Both give identical lanes.
module demux_1to4_comb
    import demux_pkg::*;
#(
    parameter int DATA_W = 1,
    parameter int ARCH   = 0
) (
    input  logic [DATA_W-1:0]                 p,
    input  sel_t                              lb,
    output logic [NUM_LANES-1:0][DATA_W-1:0]  lane
);

    if (ARCH == 0) begin : g_struct
        logic [NUM_LANES-1:0] dec;
        assign dec = onehot4(lb);
        for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
            assign lane[i] = p & {DATA_W{dec[i]}};
        end
    end else begin : g_behav
        always_comb begin
            lane = '0;
            case (lb)
                2'd0:    lane[0] = p;
                2'd1:    lane[1] = p;
                2'd2:    lane[2] = p;
                default: lane[3] = p;
            endcase
        end
    end

endmodule

// File: rtl/demux_1to4_reg.sv
// Registered 1-to-4 demux. Build with DEMUX_HOLD_EN defined to keep unselected
// lanes on update (write-addressed 4-entry register file) instead of clearing them.
module demux_1to4_reg
    import demux_pkg::*;
#(
    parameter int DATA_W = 1,
    parameter int ARCH   = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic [DATA_W-1:0]             p,
    input  logic [SEL_W-1:0]              lb,
    output logic [NUM_LANES*DATA_W-1:0]   l,
    output logic [SEL_W-1:0]              sel_q
);

    logic [NUM_LANES-1:0][DATA_W-1:0] lane;
    logic [NUM_LANES-1:0][DATA_W-1:0] l_d, l_q;
    sel_t                             sel_d;

    demux_1to4_comb #(
        .DATA_W (DATA_W),
        .ARCH   (ARCH)
    ) u_comb (
        .p    (p),
        .lb   (lb),
        .lane (lane)
    );

`ifdef DEMUX_HOLD_EN
    logic [NUM_LANES-1:0] wr;
    assign wr = onehot4(lb);
`endif

    always_comb begin
        l_d   = l_q;
        sel_d = sel_q;
        if (en) begin
            sel_d = lb;
`ifdef DEMUX_HOLD_EN
            for (int i = 0; i < NUM_LANES; i++) begin
                if (wr[i]) l_d[i] = lane[i];
            end
`else
            l_d = lane;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            l_q   <= '0;
            sel_q <= '0;
        end else begin
            l_q   <= l_d;
            sel_q <= sel_d;
        end
    end

    assign l = l_q;

endmodule

// File: tb/tb_demux_1to4_reg.sv
// Directed and random checks of demux_1to4_reg (DATA_W=1, and DATA_W=4 in both ARCHs)
// against a lane-array model of the demux rules.
module tb_demux_1to4_reg;

    logic       clk = 1'b0;
    logic       rst_n, en;
    logic [1:0] lb;
    logic [3:0] p4;
    logic [0:0] p1;

    logic [3:0]  l1;
    logic [15:0] l4a, l4b;
    logic [1:0]  s1, s4a, s4b;

    int total = 0;
    int bad   = 0;
    bit cmp_on = 1'b0;

    logic [3:0] m [4];
    logic [1:0] ms;

    always #5 clk = ~clk;
    assign p1 = p4[0];

    demux_1to4_reg #(.DATA_W(1), .ARCH(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .p(p1), .lb(lb), .l(l1), .sel_q(s1));
    demux_1to4_reg #(.DATA_W(4), .ARCH(0)) u_dut4a (
        .clk(clk), .rst_n(rst_n), .en(en), .p(p4), .lb(lb), .l(l4a), .sel_q(s4a));
    demux_1to4_reg #(.DATA_W(4), .ARCH(1)) u_dut4b (
        .clk(clk), .rst_n(rst_n), .en(en), .p(p4), .lb(lb), .l(l4b), .sel_q(s4b));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: lanes as an array, updated from the demux rules at each rising edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) m[i] = '0;
            ms = '0;
        end else if (en) begin
`ifndef DEMUX_HOLD_EN
            for (int i = 0; i < 4; i++) m[i] = '0;
`endif
            m[lb] = p4;
            ms    = lb;
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("cyc_l1",   {60'd0, l1}, {60'd0, m[3][0], m[2][0], m[1][0], m[0][0]});
            chk("cyc_l4a",  {48'd0, l4a}, {48'd0, m[3], m[2], m[1], m[0]});
            chk("cyc_l4b",  {48'd0, l4b}, {48'd0, m[3], m[2], m[1], m[0]});
            chk("cyc_s1",   {62'd0, s1},  {62'd0, ms});
            chk("cyc_s4a",  {62'd0, s4a}, {62'd0, ms});
            chk("cyc_s4b",  {62'd0, s4b}, {62'd0, ms});
        end
    end

    // Drive at a falling edge, then return at the next falling edge (one rising edge later).
    task automatic step(input logic r, input logic e, input logic [1:0] s, input logic [3:0] d);
        rst_n = r; en = e; lb = s; p4 = d;
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] e1;
        rst_n = 1'b0; en = 1'b1; lb = 2'b11; p4 = 4'hF;
        @(negedge clk);

        // Reset holds priority over en with live data.
        step(1'b0, 1'b1, 2'b11, 4'hF);
        step(1'b0, 1'b1, 2'b11, 4'hF);
        cmp_on = 1'b1;
        chk("rst_l1", {60'd0, l1}, 64'd0);
        chk("rst_s1", {62'd0, s1}, 64'd0);
        chk("rst_l4", {48'd0, l4a}, 64'd0);

        // Sweep each select with p=0 then p=1 on the 1-bit instance.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 2'(i), 4'h0);
`ifdef DEMUX_HOLD_EN
            e1 = 4'((1 << i) - 1);
`else
            e1 = 4'b0000;
`endif
            chk("sweep_p0", {60'd0, l1}, {60'd0, e1});
            step(1'b1, 1'b1, 2'(i), 4'h1);
`ifdef DEMUX_HOLD_EN
            e1 = 4'((2 << i) - 1);
`else
            e1 = 4'(1 << i);
`endif
            chk("sweep_p1", {60'd0, l1}, {60'd0, e1});
            chk("sweep_sel", {62'd0, s1}, 64'(i));
        end

        // Enable low freezes l and sel_q.
        step(1'b0, 1'b1, 2'b00, 4'h0);
        step(1'b1, 1'b1, 2'b10, 4'h1);
        chk("hold_load", {60'd0, l1}, 64'b0100);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 2'b00, 4'h1);
            chk("hold_l",   {60'd0, l1}, 64'b0100);
            chk("hold_sel", {62'd0, s1}, 64'd2);
        end

        // Write A to lane 0 then 5 to lane 3 on the 4-bit instances.
        step(1'b0, 1'b1, 2'b00, 4'h0);
        step(1'b1, 1'b1, 2'b00, 4'hA);
        chk("wr_a", {48'd0, l4a}, 64'h000A);
        step(1'b1, 1'b1, 2'b11, 4'h5);
`ifdef DEMUX_HOLD_EN
        chk("wr_5a", {48'd0, l4a}, 64'h500A);
        chk("wr_5b", {48'd0, l4b}, 64'h500A);
`else
        chk("wr_5a", {48'd0, l4a}, 64'h5000);
        chk("wr_5b", {48'd0, l4b}, 64'h5000);
`endif

        // Reset in mid-stream, then a normal load on the first free edge.
        step(1'b0, 1'b1, 2'b00, 4'h0);
        step(1'b1, 1'b1, 2'b11, 4'h1);
        chk("mid_pre", {60'd0, l1}, 64'b1000);
        step(1'b0, 1'b1, 2'b11, 4'h1);
        chk("mid_rst", {60'd0, l1}, 64'b0000);
        chk("mid_rst_sel", {62'd0, s1}, 64'd0);
        step(1'b1, 1'b1, 2'b01, 4'h1);
        chk("mid_load", {60'd0, l1}, 64'b0010);
        chk("mid_sel",  {62'd0, s1}, 64'd1);

        // Random traffic; per-cycle compare covers both architectures.
        for (int k = 0; k < 1000; k++) begin
            step(($urandom_range(0, 49) != 0), 1'($urandom), 2'($urandom), 4'($urandom));
        end

        cmp_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/demux_1to4_reg.md
Name: demux_1to4_reg

Overview:
- Registered 1-to-4 demultiplexer with a 1-bit-default data lane.
- Routes input P to one of four output lanes chosen by a 2-bit select; the other lanes read zero.
- Used as a simple address-decoded steering element in small datapaths.
- Two equivalent internal architectures are selectable by parameter (gate-level AND decode or behavioural case), so the two can be cross-checked.

Parameters:
- DATA_W, default 1: width of P and of each output lane.
- ARCH, default 0: 0 = structural decode (per-lane AND of P with decoded select); 1 = behavioural case statement. Both must be bit-identical at the ports.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: reset, synchronous, active-low.
- en, input, 1: update enable.
- p, input, DATA_W: data to steer.
- lb, input, 2: lane select. Index = {lb[1], lb[0]}, with lb[1] as MSB.
- l, output, 4*DATA_W: four lanes. Lane i occupies bits [i*DATA_W +: DATA_W], lanes 0..3.
- sel_q, output, 2: registered copy of the select used for the current l value.

Behaviour:
- Reset: on a rising clk edge with rst_n=0, l = 0 and sel_q = 0. Reset has priority over en.
- Normal update (rst_n=1, en=1) on each rising edge:
  - lane[lb] <= p.
  - every other lane <= 0, unless DEMUX_HOLD_EN is defined (see Optional Feature).
  - sel_q <= lb.
- Latency: exactly one clock from p/lb to l.
- No combinational path from inputs to outputs.
- Hold: with en=0, l and sel_q keep their values.
- Select change and data change in the same cycle: both take effect together at the next edge. There are no intermediate glitch states on l.
- At most one lane can be non-zero after any update in the default build.
- Zero data: p=0 gives l=0 entirely in the default build.
- Reset released mid-stream: the first edge with rst_n=1 and en=1 loads normally.
- X/Z on lb: no special handling required. The bench drives only known values.
- ARCH values other than 0/1: treated as 1.

Optional Feature:
- Macro: DEMUX_HOLD_EN.
- Defined: on an update, only lane[lb] is written; the three unselected lanes retain their previous values, giving a 4-entry write-addressed register file.
- Undefined (default): unselected lanes are cleared to 0 on every update, so l is a pure one-hot demux output.
- Reset clears all lanes in both builds.

Decomposition:
- Package demux_pkg:
  - localparam NUM_LANES = 4.
  - localparam SEL_W = 2.
  - typedef logic [SEL_W-1:0] sel_t.
  - function onehot4(sel_t), returning the 4-bit decoded select.
- Sub-module demux_1to4_comb: purely combinational P/select to 4-lane decode, parameterised by DATA_W and ARCH.
- The top level adds the enable, the registers, the reset and the hold feature.

Test Plan:
- Reset: rst_n=0 for 2 edges with p=1, lb=2'b11, en=1 -> l=4'b0000, sel_q=0.
- Sweep, DATA_W=1, en=1: step lb 00, 01, 10, 11 with p=0 then p=1 for each. After each edge:
  - p=0 -> l=4'b0000.
  - p=1 -> only bit lb set: lb=00 -> 0001, 01 -> 0010, 10 -> 0100, 11 -> 1000.
- Enable hold: load lb=2'b10, p=1 (l=0100), then drop en and drive lb=2'b00, p=1 for 3 edges -> l stays 0100, sel_q stays 2.
- Architecture equivalence: instantiate ARCH=0 and ARCH=1 side by side with DATA_W=4 and random p/lb/en for 1000 cycles -> l and sel_q identical every cycle.
- Hold feature, DEMUX_HOLD_EN defined, DATA_W=4: write p=4'hA to lb=0, then p=4'h5 to lb=3 -> l = {4'h5, 4'h0, 4'h0, 4'hA}.
  - Same sequence without the macro -> l = {4'h5, 4'h0, 4'h0, 4'h0}.
- Mid-operation reset: from l=1000, assert rst_n=0 for one edge with en=1 -> l=0. Next edge with rst_n=1, lb=01, p=1 -> l=0010.
